// File: rtl/snake_pkg.sv
// Shared constants and types for the snake game logic.
// Coordinates are top-left pixel positions of CELL-sized squares.
package snake_pkg;

    localparam int unsigned COORD_W        = 10;
    localparam int unsigned DIFF_W         = COORD_W + 1;
    localparam int unsigned SCREEN_W       = 640;
    localparam int unsigned SCREEN_H       = 480;
    localparam int unsigned DEF_CELL       = 10;
    localparam int unsigned DEF_MAX_TRIES  = 16;
    localparam int unsigned DEF_FALLBACK_X = SCREEN_W / 2;
    localparam int unsigned DEF_FALLBACK_Y = SCREEN_H / 2;

    typedef enum logic [1:0] {
        IDLE,
        SPAWN,
        ACTIVE
    } state_t;

    // Unsigned |a-b| with one guard bit so the subtraction never wraps.
    function automatic logic [DIFF_W-1:0] absdiff(input logic [COORD_W-1:0] a,
                                                  input logic [COORD_W-1:0] b);
        logic [DIFF_W-1:0] ea;
        logic [DIFF_W-1:0] eb;
        ea = {1'b0, a};
        eb = {1'b0, b};
        return (ea >= eb) ? (ea - eb) : (eb - ea);
    endfunction

endpackage

// File: rtl/cell_overlap.sv
// Combinational test: do two CELL-sized squares at (ax,ay) and (bx,by) overlap?
module cell_overlap
    import snake_pkg::*;
#(
    parameter int unsigned CELL = DEF_CELL
) (
    input  logic [COORD_W-1:0] ax,
    input  logic [COORD_W-1:0] ay,
    input  logic [COORD_W-1:0] bx,
    input  logic [COORD_W-1:0] by,
    output logic               hit
);

    logic [DIFF_W-1:0] dx;
    logic [DIFF_W-1:0] dy;
    logic [DIFF_W-1:0] cell_w;

    assign dx     = absdiff(ax, bx);
    assign dy     = absdiff(ay, by);
    assign cell_w = DIFF_W'(CELL);
    assign hit    = (dx < cell_w) && (dy < cell_w);

endmodule

// File: rtl/food_ctrl.sv
// Food placement and eat detection: picks a legal cell from the random candidate
// stream, holds it for the renderer, and pulses eat / bumps score when the head hits it.
module food_ctrl
    import snake_pkg::*;
#(
    parameter int unsigned CELL       = DEF_CELL,
    parameter int unsigned SCORE_W    = 8,
    parameter int unsigned MAX_TRIES  = DEF_MAX_TRIES,
    parameter int unsigned FALLBACK_X = DEF_FALLBACK_X,
    parameter int unsigned FALLBACK_Y = DEF_FALLBACK_Y
) (
    input  logic               VGAclk,
    input  logic               reset,
    input  logic [COORD_W-1:0] rX,
    input  logic [COORD_W-1:0] rY,
    input  logic [COORD_W-1:0] headX,
    input  logic [COORD_W-1:0] headY,
    input  logic               tick,
    input  logic               start,
    output logic [COORD_W-1:0] foodX,
    output logic [COORD_W-1:0] foodY,
    output logic               food_valid,
    output logic               eat,
    output logic [SCORE_W-1:0] score
);

    localparam int unsigned TRY_W = (MAX_TRIES > 1) ? $clog2(MAX_TRIES) : 1;

    state_t state_q, state_d;

    logic [COORD_W-1:0] food_x_q, food_x_d;
    logic [COORD_W-1:0] food_y_q, food_y_d;
    logic [COORD_W-1:0] prev_x_q, prev_x_d;
    logic [COORD_W-1:0] prev_y_q, prev_y_d;
    logic               valid_q, valid_d;
    logic               eat_q, eat_d;
    logic [SCORE_W-1:0] score_q, score_d;
    logic [TRY_W-1:0]   tries_q, tries_d;

    logic cand_hit;
    logic eat_hit;
    logic dup;
    logic reject;
    logic last_try;
    logic food_hit;

    cell_overlap #(.CELL(CELL)) u_cand_overlap (
        .ax  (rX),
        .ay  (rY),
        .bx  (headX),
        .by  (headY),
        .hit (cand_hit)
    );

    cell_overlap #(.CELL(CELL)) u_food_overlap (
        .ax  (headX),
        .ay  (headY),
        .bx  (food_x_q),
        .by  (food_y_q),
        .hit (eat_hit)
    );

    // Re-spawning on the cell just eaten would look like the food never moved.
    assign dup      = (rX == prev_x_q) && (rY == prev_y_q);
    assign reject   = cand_hit || dup;
    assign last_try = (tries_q == TRY_W'(MAX_TRIES - 1));
    assign food_hit = tick && eat_hit;

    always_ff @(posedge VGAclk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            state_d = SPAWN;
        end else begin
            unique case (state_q)
                IDLE:    state_d = IDLE;
                SPAWN:   if (!reject || last_try) state_d = ACTIVE;
                ACTIVE:  if (food_hit) state_d = SPAWN;
                default: state_d = IDLE;
            endcase
        end
    end

    always_comb begin
        food_x_d = food_x_q;
        food_y_d = food_y_q;
        prev_x_d = prev_x_q;
        prev_y_d = prev_y_q;
        valid_d  = valid_q;
        eat_d    = 1'b0;
        score_d  = score_q;
        tries_d  = tries_q;
        if (start) begin
            // Restart wins over a same-cycle hit: no eat, no score bump.
            valid_d = 1'b0;
            score_d = '0;
            tries_d = '0;
        end else begin
            unique case (state_q)
                SPAWN: begin
                    valid_d = 1'b0;
                    if (!reject) begin
                        food_x_d = rX;
                        food_y_d = rY;
                        prev_x_d = rX;
                        prev_y_d = rY;
                        valid_d  = 1'b1;
                    end else if (last_try) begin
                        food_x_d = COORD_W'(FALLBACK_X);
                        food_y_d = COORD_W'(FALLBACK_Y);
                        prev_x_d = COORD_W'(FALLBACK_X);
                        prev_y_d = COORD_W'(FALLBACK_Y);
                        valid_d  = 1'b1;
                    end else begin
                        tries_d = tries_q + 1'b1;
                    end
                end
                ACTIVE: begin
                    if (food_hit) begin
                        eat_d   = 1'b1;
                        valid_d = 1'b0;
                        tries_d = '0;
                        if (score_q != {SCORE_W{1'b1}}) begin
                            score_d = score_q + 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge VGAclk or posedge reset) begin
        if (reset) begin
            food_x_q <= '0;
            food_y_q <= '0;
            prev_x_q <= '0;
            prev_y_q <= '0;
            valid_q  <= 1'b0;
            eat_q    <= 1'b0;
            score_q  <= '0;
            tries_q  <= '0;
        end else begin
            food_x_q <= food_x_d;
            food_y_q <= food_y_d;
            prev_x_q <= prev_x_d;
            prev_y_q <= prev_y_d;
            valid_q  <= valid_d;
            eat_q    <= eat_d;
            score_q  <= score_d;
            tries_q  <= tries_d;
        end
    end

    assign foodX      = food_x_q;
    assign foodY      = food_y_q;
    assign food_valid = valid_q;
    assign eat        = eat_q;
    assign score      = score_q;

endmodule

// File: doc/food_ctrl.md
Name: food_ctrl

Overview:
- Downstream consumer of the free-running random coordinate generator, which drives rX/rY with a new candidate every VGAclk.
- Picks a valid food cell from the candidate stream and holds it stable for the renderer.
- Detects the snake head eating the food on each game tick, then pulses eat/grow to the snake-body logic and bumps the score.
- Sits between the random generator, the snake movement logic and the VGA draw/score display.

Parameters:
- CELL, 10, cell size in pixels for the overlap test.
- SCORE_W, 8, score counter width.
- MAX_TRIES, 16, rejected candidates allowed before fallback placement.
- FALLBACK_X, 320, food X used when retries are exhausted.
- FALLBACK_Y, 240, food Y used when retries are exhausted.

Ports:
- VGAclk  in  1  system clock (pixel clock domain).
- reset  in  1  asynchronous, active-high reset.
- rX  in  10  candidate food X from the random generator (changes every clock).
- rY  in  10  candidate food Y from the random generator.
- headX  in  10  snake head top-left X; valid whenever tick=1.
- headY  in  10  snake head top-left Y.
- tick  in  1  one-cycle game-update strobe.
- start  in  1  one-cycle new-game request.
- foodX  out  10  registered food X.
- foodY  out  10  registered food Y.
- food_valid  out  1  food position is stable and drawable.
- eat  out  1  one-cycle pulse when food is consumed.
- score  out  SCORE_W  food eaten since the last start.

Behaviour:
- Reset (async, active-high): state=IDLE, foodX=0, foodY=0, food_valid=0, eat=0, score=0, try counter=0, prevX/prevY=0.
- States: IDLE, SPAWN, ACTIVE.
- IDLE:
  - outputs hold their values.
  - start=1 -> score=0, tries=0, go to SPAWN.
- SPAWN:
  - food_valid=0.
  - Each cycle, sample rX/rY as the candidate.
  - Reject the candidate if it overlaps the head (|rX-headX|<CELL and |rY-headY|<CELL, computed unsigned with 11-bit differences) or if rX==prevX and rY==prevY.
  - Accept: foodX<=rX, foodY<=rY, prevX/prevY<=candidate, food_valid<=1 at the same edge, go to ACTIVE. Latency from entering SPAWN is 1 cycle when the first candidate is accepted.
  - Reject: tries++.
  - When tries==MAX_TRIES-1 and the candidate is rejected: load FALLBACK_X/FALLBACK_Y unconditionally, food_valid<=1, go to ACTIVE.
- ACTIVE:
  - food_valid=1; foodX/foodY are stable.
  - On tick=1, apply the overlap test against foodX/foodY. On a hit:
    - eat<=1 for exactly one cycle, on the next edge.
    - score++, saturating at 2^SCORE_W-1.
    - food_valid<=0, tries<=0, go to SPAWN.
  - tick=1 with no hit: no change.
- start=1 in SPAWN or ACTIVE:
  - restart: score=0, tries=0, eat=0, go to SPAWN.
  - start has priority over a simultaneous tick hit, so no eat and no score increment occur.
- eat is never asserted outside the cycle after an ACTIVE hit.
- A tick in SPAWN or IDLE is ignored.
- Arithmetic: overlap differences are computed at 11 bits (abs of a-b). Comparisons use unsigned CELL widened to 11 bits. score wraps never (saturates).
- Reset mid-operation clears everything asynchronously. The first edge after reset deasserts is in IDLE.

Decomposition:
- Shared package (snake_pkg):
  - CELL, screen bounds (640/480), FALLBACK_X/Y defaults.
  - the state enum {IDLE, SPAWN, ACTIVE}.
  - coordinate width constant (10).
- One natural sub-module: cell_overlap (combinational, inputs ax, ay, bx, by; output hit). It is instantiated twice: candidate-vs-head in SPAWN and head-vs-food in ACTIVE.
- The FSM, try counter and score counter stay in food_ctrl.

Test Plan:
- Reset then start: rX=100, rY=200, head=(300,300) -> next edge foodX=100, foodY=200, food_valid=1, score=0, state ACTIVE.
- Eat:
  - food at (100,200); pulse tick with head=(105,195) -> eat=1 for exactly 1 cycle, score=1, food_valid=0.
  - next candidate (400,50) -> food=(400,50), valid=1.
- Reject:
  - in SPAWN, head=(100,200); rX/rY stream (100,200), (95,205), then (500,400) -> first two rejected (tries=2), food=(500,400).
  - separately, a candidate equal to the previous food position is rejected.
- Fallback: hold rX=headX=200, rY=headY=200 for 16 cycles in SPAWN -> food=(320,240), valid=1 after exactly 16 cycles.
- Priority and saturation:
  - start and a hitting tick in the same cycle -> eat stays 0, score=0, state SPAWN.
  - with SCORE_W=2, four eats -> score stays at 3.
- Async reset: assert reset mid-ACTIVE, between clock edges -> foodX/foodY, score and food_valid go to 0 immediately. After release, tick is ignored until start.
